// File: rtl/z80_bus_arbiter_if.sv
// z80_bus_arbiter_if
//   Bundle of the arbitration and access-control signals between the Z80 bus
//   masters / address decoder / sysmux and the bus arbiter.
//   Modports:
//     master : bus side (masters, decoder, slaves); drives req/strobe/slave_ena/
//              wait_cfg/slave_ready, observes grant/msel/ssel/mwait_n/errors.
//     slave  : arbiter side; the reverse directions.
//   Signals:
//     req[MASTER_QTY]          master i requests/holds the bus
//     grant[MASTER_QTY]        one-hot ownership, all-zero when no owner
//     msel[MW]                 current/last owner index
//     strobe                   owning master's cycle active
//     slave_ena[SLAVE_QTY]     address-decoder enables
//     wait_cfg[SLAVE_QTY*WAIT_W] per-slave wait counts
//     slave_ready[SLAVE_QTY]   per-slave ready
//     ssel[SW]                 selected slave
//     mwait_n                  active-low wait to the owner
//     bus_err                  one-cycle error pulse
//     err_slave[SW]            slave index of the last timeout
//     err_unmapped             last error was an unmapped access
interface z80_bus_arbiter_if #(
  parameter int MASTER_QTY = 2,
  parameter int SLAVE_QTY  = 4,
  parameter int WAIT_W     = 4
);
  localparam int MW = (MASTER_QTY > 1) ? $clog2(MASTER_QTY) : 1;
  localparam int SW = (SLAVE_QTY > 1) ? $clog2(SLAVE_QTY) : 1;

  logic [MASTER_QTY-1:0]       req;
  logic [MASTER_QTY-1:0]       grant;
  logic [MW-1:0]               msel;
  logic                        strobe;
  logic [SLAVE_QTY-1:0]        slave_ena;
  logic [SLAVE_QTY*WAIT_W-1:0] wait_cfg;
  logic [SLAVE_QTY-1:0]        slave_ready;
  logic [SW-1:0]               ssel;
  logic                        mwait_n;
  logic                        bus_err;
  logic [SW-1:0]               err_slave;
  logic                        err_unmapped;

  modport master (
    output req, strobe, slave_ena, wait_cfg, slave_ready,
    input  grant, msel, ssel, mwait_n, bus_err, err_slave, err_unmapped
  );

  modport slave (
    input  req, strobe, slave_ena, wait_cfg, slave_ready,
    output grant, msel, ssel, mwait_n, bus_err, err_slave, err_unmapped
  );
endinterface

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter
//   Round-robin bus arbiter with dead-cycle handover plus per-slave wait-state
//   controller with slave-ready extension, access timeout and unmapped-access
//   error reporting.
//   Ports:
//     clk  system clock
//     rst  synchronous active-high reset
//     bus  z80_bus_arbiter_if.slave (request/grant, strobe, decoder enables,
//          wait config, slave ready, ssel, mwait_n, error reporting)
module z80_bus_arbiter #(
  parameter int MASTER_QTY = 2,
  parameter int SLAVE_QTY  = 4,
  parameter int WAIT_W     = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           rst,
  z80_bus_arbiter_if.slave bus
);
  localparam int MW = (MASTER_QTY > 1) ? $clog2(MASTER_QTY) : 1;
  localparam int SW = (SLAVE_QTY > 1) ? $clog2(SLAVE_QTY) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_HANDOVER} arb_e;
  typedef enum logic [1:0] {ACC_IDLE, ACC_WAIT, ACC_DONE, ACC_ERR} acc_e;

  arb_e              arb_q, arb_d;
  logic [MW-1:0]     owner_q, owner_d;
  logic [MW-1:0]     rr_q, rr_d;
  acc_e              acc_q, acc_d;
  logic [SW-1:0]     ssel_q, ssel_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              bus_err_q, bus_err_d;
  logic [SW-1:0]     err_slave_q, err_slave_d;
  logic              err_unm_q, err_unm_d;

  logic [SW-1:0]     sel_c;
  logic              sel_hit;
  logic [WAIT_W-1:0] n_c;
  logic              rdy_start;
  logic              rdy_cur;
  logic              mwait_n_c;
  logic [SW-1:0]     ssel_c;
  logic [MW-1:0]     win;
  logic              win_found;
  logic              req_owner;
  logic [MASTER_QTY-1:0] grant_c;

  // Decoder lookup: lowest-index enabled slave, its wait count and ready.
  always_comb begin
    sel_c     = ssel_q;
    sel_hit   = 1'b0;
    n_c       = '0;
    rdy_start = 1'b0;
    rdy_cur   = 1'b0;
    for (int i = SLAVE_QTY - 1; i >= 0; i--) begin
      if (bus.slave_ena[i]) begin
        sel_c   = SW'(i);
        sel_hit = 1'b1;
      end
    end
    for (int i = 0; i < SLAVE_QTY; i++) begin
      if (SW'(i) == sel_c) begin
        n_c       = bus.wait_cfg[i*WAIT_W +: WAIT_W];
        rdy_start = bus.slave_ready[i];
      end
      if (SW'(i) == ssel_q) rdy_cur = bus.slave_ready[i];
    end
  end

  // Access FSM. tcnt_q tracks the cycle index k while waiting; wcnt_q holds the
  // remaining fixed wait cycles (N-1 loaded in cycle 0).
  always_comb begin
    acc_d       = acc_q;
    ssel_d      = ssel_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    bus_err_d   = 1'b0;
    err_slave_d = err_slave_q;
    err_unm_d   = err_unm_q;
    mwait_n_c   = 1'b1;
    ssel_c      = ssel_q;
    case (acc_q)
      ACC_IDLE: begin
        if (bus.strobe) begin
          if (!sel_hit) begin
            acc_d     = ACC_DONE;
            bus_err_d = 1'b1;
            err_unm_d = 1'b1;
          end else begin
            ssel_c = sel_c;
            ssel_d = sel_c;
            if (n_c == '0 && rdy_start) begin
              acc_d = ACC_DONE;
            end else begin
              mwait_n_c = 1'b0;
              acc_d     = ACC_WAIT;
              wcnt_d    = (n_c == '0) ? '0 : n_c - 1'b1;
              tcnt_d    = TW'(1);
            end
          end
        end
      end
      ACC_WAIT: begin
        if (!bus.strobe) begin
          // Master abandoned the cycle: no error, just go idle.
          acc_d = ACC_IDLE;
        end else if (wcnt_q == '0 && rdy_cur) begin
          acc_d = ACC_DONE;
        end else begin
          mwait_n_c = 1'b0;
          if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
          if (tcnt_q == TW'(TIMEOUT - 1)) begin
            // Next cycle is k == TIMEOUT: release the master and flag it.
            acc_d       = ACC_ERR;
            bus_err_d   = 1'b1;
            err_slave_d = ssel_q;
            err_unm_d   = 1'b0;
          end else if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      ACC_DONE, ACC_ERR: begin
        acc_d = bus.strobe ? ACC_DONE : ACC_IDLE;
      end
      default: acc_d = ACC_IDLE;
    endcase
  end

  // Arbitration FSM with round-robin search starting at rr_q.
  always_comb begin
    int idx;
    int nxt;
    arb_d     = arb_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    win       = owner_q;
    win_found = 1'b0;
    req_owner = 1'b0;
    grant_c   = '0;
    idx       = 0;
    nxt       = 0;
    for (int off = 0; off < MASTER_QTY; off++) begin
      idx = int'(rr_q) + off;
      if (idx >= MASTER_QTY) idx = idx - MASTER_QTY;
      for (int i = 0; i < MASTER_QTY; i++) begin
        if (!win_found && i == idx && bus.req[i]) begin
          win_found = 1'b1;
          win       = MW'(i);
        end
      end
    end
    for (int i = 0; i < MASTER_QTY; i++) begin
      if (MW'(i) == owner_q) req_owner = bus.req[i];
      grant_c[i] = (arb_q == ARB_OWN) && (MW'(i) == owner_q);
    end
    case (arb_q)
      ARB_IDLE: begin
        if (win_found) begin
          arb_d   = ARB_OWN;
          owner_d = win;
          nxt     = int'(win) + 1;
          if (nxt >= MASTER_QTY) nxt = 0;
          rr_d    = MW'(nxt);
        end
      end
      ARB_OWN: begin
        if (!(req_owner || bus.strobe || acc_q != ACC_IDLE)) arb_d = ARB_HANDOVER;
      end
      ARB_HANDOVER: arb_d = ARB_IDLE;
      default:      arb_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_q       <= ARB_IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      acc_q       <= ACC_IDLE;
      ssel_q      <= '0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      bus_err_q   <= 1'b0;
      err_slave_q <= '0;
      err_unm_q   <= 1'b0;
    end else begin
      arb_q       <= arb_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      acc_q       <= acc_d;
      ssel_q      <= ssel_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      bus_err_q   <= bus_err_d;
      err_slave_q <= err_slave_d;
      err_unm_q   <= err_unm_d;
    end
  end

  assign bus.grant        = grant_c;
  assign bus.msel         = owner_q;
  assign bus.ssel         = ssel_c;
  assign bus.mwait_n      = mwait_n_c;
  assign bus.bus_err      = bus_err_q;
  assign bus.err_slave    = err_slave_q;
  assign bus.err_unmapped = err_unm_q;
endmodule
